// File: rtl/crc16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc16_pkg
// Brief    : Shared types, constants and CRC-16 word helper for crc16_frame_ctrl.
// Revision : 1.0
// ============================================================================
package crc16_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        CRC_OUT = 2'd2,
        STATUS  = 2'd3
    } state_t;

    localparam logic        MODE_GEN    = 1'b0;
    localparam logic        MODE_CHECK  = 1'b1;
    localparam logic [15:0] DEF_SEED    = 16'hFFFF;
    localparam logic [15:0] DEF_XOR_OUT = 16'h0000;
    localparam logic [15:0] CRC_POLY    = 16'h1021;

    // MSB-first CCITT polynomial, one full 16-bit word per call
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [15:0] data_in);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data_in[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc16.sv
`default_nettype none
// ============================================================================
// Module   : crc16
// Brief    : Combinational CRC-16 update cell, one 16-bit word per evaluation.
// Revision : 1.0
// ============================================================================
module crc16
    import crc16_pkg::*;
(
    input  logic [15:0] CRC_old,
    input  logic [15:0] Data,
    output logic [15:0] CRC_new
);

    always_comb begin
        CRC_new = crc16_word(CRC_old, Data);
    end

endmodule
`default_nettype wire

// File: rtl/crc16_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : crc16_frame_ctrl
// Brief    : Frame sequencer: forwards a word stream and appends (GEN) or
//            verifies (CHECK) a trailing CRC-16 word.
// Revision : 1.0
// ============================================================================
module crc16_frame_ctrl
    import crc16_pkg::*;
#(
    parameter logic [15:0] SEED    = DEF_SEED,
    parameter logic [15:0] XOR_OUT = DEF_XOR_OUT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic [15:0]      crc_value,
    output logic [CNT_W-1:0] frame_len
);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [15:0]        crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               chk_q, chk_d;
    logic               m_valid_q, m_valid_d;
    logic [15:0]        m_data_q, m_data_d;
    logic               m_last_q, m_last_d;
    logic               done_q, done_d;
    logic               crc_ok_q, crc_ok_d;
    logic [15:0]        crc_value_q, crc_value_d;
    logic [CNT_W-1:0]   frame_len_q, frame_len_d;

    logic [15:0]        crc_next;
    logic [15:0]        crc_final;
    logic               can_load;
    logic               s_hs;

    crc16 u_crc16 (
        .CRC_old (crc_q),
        .Data    (s_data),
        .CRC_new (crc_next)
    );

    assign crc_final = crc_q ^ XOR_OUT;
    assign can_load  = !m_valid_q || m_ready;
    // abort wins over a handshake, so the word is never taken from upstream
    assign s_ready   = (state_q == DATA) && can_load && !abort;
    assign s_hs      = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        m_valid_d   = m_valid_q && !m_ready;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        done_d      = 1'b0;
        crc_ok_d    = crc_ok_q;
        crc_value_d = crc_value_q;
        frame_len_d = frame_len_q;

        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_d  = mode;
                        crc_d   = SEED;
                        cnt_d   = '0;
                        chk_d   = 1'b0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (s_hs) begin
                        m_valid_d = 1'b1;
                        m_data_d  = s_data;
                        if (!(&cnt_q)) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (!s_last) begin
                            crc_d    = crc_next;
                            m_last_d = 1'b0;
                        end else if (mode_q == MODE_GEN) begin
                            crc_d    = crc_next;
                            m_last_d = 1'b0;
                            state_d  = CRC_OUT;
                        end else begin
                            // received CRC word is compared, never folded
                            chk_d    = (s_data == crc_final);
                            m_last_d = 1'b1;
                            state_d  = STATUS;
                        end
                    end
                end
                CRC_OUT: begin
                    chk_d = 1'b1;
                    if (can_load) begin
                        m_valid_d = 1'b1;
                        m_data_d  = crc_final;
                        m_last_d  = 1'b1;
                        state_d   = STATUS;
                    end
                end
                STATUS: begin
                    if (can_load) begin
                        done_d      = 1'b1;
                        crc_ok_d    = chk_q;
                        crc_value_d = crc_final;
                        frame_len_d = cnt_q;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_GEN;
            crc_q       <= SEED;
            cnt_q       <= '0;
            chk_q       <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_value_q <= '0;
            frame_len_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            done_q      <= done_d;
            crc_ok_q    <= crc_ok_d;
            crc_value_q <= crc_value_d;
            frame_len_q <= frame_len_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign done      = done_q;
    assign crc_ok    = crc_ok_q;
    assign crc_value = crc_value_q;
    assign frame_len = frame_len_q;

endmodule
`default_nettype wire

// File: tb/tb_crc16_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc16_frame_ctrl
// Brief    : Directed table-driven bench for crc16_frame_ctrl (two seeds).
// Revision : 1.0
// ============================================================================
module tb_crc16_frame_ctrl;
    import crc16_pkg::*;

    localparam logic [15:0] SEED_B = 16'hFFFF;
    localparam logic [15:0] XOR_B  = 16'h5A5A;
    localparam int          NV     = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, mode, abort, s_valid, s_last;
    logic        m_ready = 1'b1;
    logic [15:0] s_data;

    logic        s_ready_a, m_valid_a, m_last_a, busy_a, done_a, crc_ok_a;
    logic [15:0] m_data_a, crc_value_a, frame_len_a;
    logic        s_ready_b, m_valid_b, m_last_b, busy_b, done_b, crc_ok_b;
    logic [15:0] m_data_b, crc_value_b, frame_len_b;

    crc16_frame_ctrl #(.SEED(16'h0000), .XOR_OUT(16'h0000), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_last(m_last_a),
        .busy(busy_a), .done(done_a), .crc_ok(crc_ok_a), .crc_value(crc_value_a),
        .frame_len(frame_len_a)
    );

    crc16_frame_ctrl #(.SEED(SEED_B), .XOR_OUT(XOR_B), .CNT_W(16)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_last(m_last_b),
        .busy(busy_b), .done(done_b), .crc_ok(crc_ok_b), .crc_value(crc_value_b),
        .frame_len(frame_len_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // shift-register form: XOR the whole word in, then 16 polynomial steps
    function automatic logic [15:0] golden(input logic [15:0] c_in, input logic [15:0] d);
        logic [15:0] c;
        c = c_in ^ d;
        for (int k = 0; k < 16; k++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    logic [16:0] beats_a[$];
    logic [16:0] beats_b[$];
    int          cyc = 0, last_hs_cyc = 0, done_cyc = 0, done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_out = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (prev_stall)
                check("stall_hold", {15'd0, m_last_a, m_data_a}, {15'd0, prev_out});
            if (m_valid_a && !m_ready)
                check("s_ready_full", {31'd0, s_ready_a}, 32'd0);
            if (m_valid_a && m_ready) begin
                beats_a.push_back({m_last_a, m_data_a});
                if (m_last_a) last_hs_cyc = cyc;
            end
            if (m_valid_b && m_ready) beats_b.push_back({m_last_b, m_data_b});
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_stall = reset_n && m_valid_a && !m_ready;
        prev_out   = {m_last_a, m_data_a};
    end

    // downstream ready: always 1, or the repeating 1,0,0,1 pattern
    logic bp_en = 1'b0;
    int   ph    = 0;
    always @(posedge clk) begin
        #1;
        m_ready = bp_en ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
        ph++;
    end

    logic [15:0] fw [3];

    task automatic run_frame(input logic md, input int n, input int abort_at, input int restart_at);
        int guard;
        logic acc;
        beats_a.delete();
        beats_b.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = md;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = fw[i];
            s_last  = (i == n - 1);
            if (i == restart_at) begin
                start = 1'b1;
                mode  = ~md;
            end
            if (i == abort_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort   = 1'b0;
                s_valid = 1'b0;
                s_last  = 1'b0;
                check("abort_busy", {31'd0, busy_a}, 32'd0);
                check("abort_mvalid", {31'd0, m_valid_a}, 32'd0);
                return;
            end
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 40) begin
                @(negedge clk);
                acc = s_ready_a;
                @(posedge clk); #1;
                guard++;
            end
            start = 1'b0;
            mode  = md;
            check($sformatf("accept_w%0d", i), {31'd0, acc}, 32'd1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        guard   = 0;
        while (done_cnt == 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", {31'd0, done_cnt > 0}, 32'd1);
    endtask

    task automatic verify(input int id, input logic md, input int n,
                          input logic [15:0] ecrc, input logic eok);
        int          nb;
        logic [15:0] gb;
        nb = (md == MODE_GEN) ? n + 1 : n;
        check($sformatf("v%0d.beats", id), beats_a.size(), nb);
        for (int i = 0; i < n && i < beats_a.size(); i++)
            check($sformatf("v%0d.beat%0d", id, i), {15'd0, beats_a[i]},
                  {15'd0, (md == MODE_CHECK) && (i == n - 1), fw[i]});
        if (md == MODE_GEN && beats_a.size() == nb) begin
            check($sformatf("v%0d.crc_beat", id), {15'd0, beats_a[n]}, {15'd0, 1'b1, ecrc});
            gb = SEED_B;
            for (int i = 0; i < n; i++) gb = golden(gb, fw[i]);
            check($sformatf("v%0d.b_crc_beat", id),
                  (beats_b.size() == nb) ? {15'd0, beats_b[n]} : 32'hFFFF_FFFF,
                  {15'd0, 1'b1, gb ^ XOR_B});
            check($sformatf("v%0d.b_crc_value", id), {16'd0, crc_value_b}, {16'd0, gb ^ XOR_B});
        end
        check($sformatf("v%0d.crc_value", id), {16'd0, crc_value_a}, {16'd0, ecrc});
        check($sformatf("v%0d.crc_ok", id), {31'd0, crc_ok_a}, {31'd0, eok});
        check($sformatf("v%0d.frame_len", id), {16'd0, frame_len_a}, n);
        check($sformatf("v%0d.done_lat", id), done_cyc - last_hs_cyc, 1);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d.done_once", id), done_cnt, 1);
    endtask

    typedef struct {
        logic        md;
        int          n;
        logic [15:0] w0, w1, w2;
        logic        bp;
        logic [15:0] ecrc;
        logic        eok;
    } vec_t;

    function automatic vec_t mk(input logic md, input int n, input logic [15:0] w0,
                                input logic [15:0] w1, input logic [15:0] w2,
                                input logic bp, input logic [15:0] ecrc, input logic eok);
        vec_t v;
        v.md = md; v.n = n; v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.bp = bp; v.ecrc = ecrc; v.eok = eok;
        return v;
    endfunction

    vec_t vt [NV];

    initial begin
        // seed-0 golden values: word 0x0001 -> 0x1021, word 0x0100 -> 0x3331
        vt[0] = mk(MODE_GEN,   3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        vt[1] = mk(MODE_GEN,   1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h1021, 1'b1);
        vt[2] = mk(MODE_GEN,   2, 16'h0000, 16'h0100, 16'h0000, 1'b1, 16'h3331, 1'b1);
        vt[3] = mk(MODE_GEN,   2, 16'h0000, 16'h0001, 16'h0000, 1'b0, 16'h1021, 1'b1);
        vt[4] = mk(MODE_CHECK, 2, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        vt[5] = mk(MODE_CHECK, 2, 16'h0000, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0);
        vt[6] = mk(MODE_CHECK, 1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        vt[7] = mk(MODE_CHECK, 2, 16'h0001, 16'h1021, 16'h0000, 1'b0, 16'h1021, 1'b1);
        vt[8] = mk(MODE_CHECK, 2, 16'h0100, 16'h3330, 16'h0000, 1'b1, 16'h3331, 1'b0);

        reset_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst.m_valid",   {31'd0, m_valid_a}, 32'd0);
        check("rst.s_ready",   {31'd0, s_ready_a}, 32'd0);
        check("rst.busy",      {31'd0, busy_a}, 32'd0);
        check("rst.done",      {31'd0, done_a}, 32'd0);
        check("rst.crc_ok",    {31'd0, crc_ok_a}, 32'd0);
        check("rst.crc_value", {16'd0, crc_value_b}, 32'd0);
        check("rst.frame_len", {16'd0, frame_len_a}, 32'd0);

        for (int k = 0; k < NV; k++) begin
            fw[0] = vt[k].w0; fw[1] = vt[k].w1; fw[2] = vt[k].w2;
            bp_en = vt[k].bp;
            run_frame(vt[k].md, vt[k].n, -1, -1);
            bp_en = 1'b0;
            verify(k, vt[k].md, vt[k].n, vt[k].ecrc, vt[k].eok);
        end

        fw[0] = 16'h1234; fw[1] = 16'hABCD; fw[2] = 16'h0000;
        run_frame(MODE_GEN, 2, -1, -1);
        verify(9, MODE_GEN, 2, golden(golden(16'h0000, 16'h1234), 16'hABCD), 1'b1);

        fw[0] = 16'h0000; fw[1] = 16'h0000; fw[2] = 16'h0000;
        run_frame(MODE_GEN, 3, 1, -1);
        repeat (4) @(negedge clk);
        check("abort.no_done",   done_cnt, 0);
        check("abort.beats",     beats_a.size(), 1);
        check("abort.frame_len", {16'd0, frame_len_a}, 32'd2);
        check("abort.crc_value", {16'd0, crc_value_a},
              {16'd0, golden(golden(16'h0000, 16'h1234), 16'hABCD)});

        fw[0] = 16'h0000;
        run_frame(MODE_GEN, 1, -1, -1);
        verify(10, MODE_GEN, 1, 16'h0000, 1'b1);

        fw[0] = 16'h0000; fw[1] = 16'h0001;
        run_frame(MODE_GEN, 2, -1, 1);
        verify(11, MODE_GEN, 2, 16'h1021, 1'b1);

        @(posedge clk); #1;
        start = 1'b1; mode = MODE_GEN;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = 16'h00FF; s_last = 1'b0;
        @(posedge clk); #1;
        #2 reset_n = 1'b0;
        #1;
        check("midrst.busy",      {31'd0, busy_a}, 32'd0);
        check("midrst.m_valid",   {31'd0, m_valid_a}, 32'd0);
        check("midrst.s_ready",   {31'd0, s_ready_a}, 32'd0);
        check("midrst.m_data",    {16'd0, m_data_a}, 32'd0);
        check("midrst.frame_len", {16'd0, frame_len_a}, 32'd0);
        check("midrst.crc_value", {16'd0, crc_value_b}, 32'd0);
        s_valid = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("midrst.idle", {31'd0, busy_a}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
